ntt_stage_sched: RTL and testbench

Sequencer for an in-place N-point NTT built on one shared `ntt2_pipeline_top` butterfly (33-bit residues mod p = 2^33 − 2^20 + 1). It generates coefficient-RAM read and write addresses, twiddle-ROM addresses and butterfly enables for all log2(N) stages. It enforces a drain barrier between stages so that no read overtakes an outstanding write. Datapath values never pass through this block; it drives control and addresses only.

---
 rtl/ntt_stage_sched_if.sv | 21 ++
 rtl/ntt_stage_sched.sv | 92 +++++++++
 tb/tb_ntt_stage_sched.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ntt_stage_sched_if.sv
// ntt_stage_sched_if: coefficient-RAM, twiddle-ROM and butterfly control bus.
// The scheduler is the master; the RAM/ROM/butterfly side is the slave.
interface ntt_stage_sched_if #(parameter int LOGN = 4);
    logic            rd_en;
    logic [LOGN-1:0] rd_addr_x;
    logic [LOGN-1:0] rd_addr_y;
    logic [LOGN-2:0] tw_addr;
    logic            bf_en;
    logic            bf_valid;
    logic            wr_en;
    logic [LOGN-1:0] wr_addr_x;
    logic [LOGN-1:0] wr_addr_y;
    modport master (
        output rd_en, rd_addr_x, rd_addr_y, tw_addr, bf_en, wr_en, wr_addr_x, wr_addr_y,
        input  bf_valid
    );
    modport slave (
        input  rd_en, rd_addr_x, rd_addr_y, tw_addr, bf_en, wr_en, wr_addr_x, wr_addr_y,
        output bf_valid
    );
endinterface

// File: rtl/ntt_stage_sched.sv
// ntt_stage_sched: in-place DIF NTT sequencer driving one shared butterfly.
// Issues N/2 butterflies per stage and drains the pipeline before the next stage.
module ntt_stage_sched #(
    parameter int LOGN   = 4,
    parameter int BF_LAT = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [LOGN-1:0]   stage,
    output logic              err,
    ntt_stage_sched_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    localparam logic [LOGN-1:0] LAST = LOGN'(LOGN - 1);
    state_t                  state;
    logic [LOGN-2:0]         j, ji, t, rd_tw;
    logic [LOGN-1:0]         s, si, sh, h, k, x, cnt, cnt_nxt, rd_x, rd_y;
    logic                    rd_en, wr, issue;
    logic [BF_LAT:0][2*LOGN:0] dl;
    assign wr = dl[BF_LAT][2*LOGN];
    // look-ahead count lets the next stage issue the cycle after the last write
    assign cnt_nxt = cnt + LOGN'(rd_en) - LOGN'(wr);
    always_comb begin
        si    = (state == IDLE) ? '0 : (state == DRAIN) ? s + 1'b1 : s;
        ji    = (state == ISSUE) ? j + 1'b1 : '0;
        sh    = LAST - si;
        h     = LOGN'(1) << sh;
        k     = {1'b0, ji} & (h - 1'b1);
        x     = (({1'b0, ji} >> sh) << (sh + 1'b1)) | k;
        t     = (LOGN-1)'(k << si);
        issue = (state == IDLE && start) || (state == ISSUE && !(&j)) ||
                (state == DRAIN && cnt_nxt == '0 && s != LAST);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            s     <= '0;
            j     <= '0;
            cnt   <= '0;
            rd_en <= 1'b0;
            rd_x  <= '0;
            rd_y  <= '0;
            rd_tw <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            err   <= (state == IDLE && start) ? 1'b0 : err | (bus.bf_valid != wr);
            rd_en <= issue;
            done  <= 1'b0;
            if (issue) begin
                s     <= si;
                j     <= ji;
                rd_x  <= x;
                rd_y  <= x | h;
                rd_tw <= t;
            end
            case (state)
                IDLE:  if (start) begin
                    state <= ISSUE;
                    busy  <= 1'b1;
                end
                ISSUE: if (&j) state <= DRAIN;
                DRAIN: if (cnt_nxt == '0) begin
                    state <= (s == LAST) ? DONE : ISSUE;
                    done  <= (s == LAST);
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) dl <= '0;
        else        dl <= {dl[BF_LAT-1:0], {rd_en, rd_x, rd_y}};
    end
    assign stage         = s;
    assign bus.rd_en     = rd_en;
    assign bus.rd_addr_x = rd_x;
    assign bus.rd_addr_y = rd_y;
    assign bus.tw_addr   = rd_tw;
    assign bus.bf_en     = dl[0][2*LOGN];
    assign bus.wr_en     = wr;
    assign bus.wr_addr_x = dl[BF_LAT][2*LOGN-1:LOGN];
    assign bus.wr_addr_y = dl[BF_LAT][LOGN-1:0];
endmodule

// File: tb/tb_ntt_stage_sched.sv
// tb_ntt_stage_sched: directed bench for the NTT stage scheduler (LOGN=4, BF_LAT=6).
// Cycle c counts edges after the cycle in which start is raised (cycle 0).
module tb_ntt_stage_sched;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b1;
    logic       kill = 1'b0;
    logic       busy, done, err;
    logic [3:0] stage;
    logic [5:0] sr;
    int         tests = 0;
    int         fails = 0;

    typedef struct {
        logic       rd, wr, bfe, bsy, dn, er;
        logic [3:0] x, y, wx, wy, st;
        logic [2:0] tw;
    } smp_t;
    typedef struct {
        logic en;
        int   x, y, tw, st;
    } rd_t;
    smp_t tr [0:70];

    ntt_stage_sched_if #(.LOGN(4)) bus ();

    ntt_stage_sched #(.LOGN(4), .BF_LAT(6)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .done(done), .stage(stage), .err(err), .bus(bus)
    );

    always #5 clk = ~clk;

    // butterfly model: valid is en delayed by BF_LAT, optionally suppressed
    always @(posedge clk or negedge reset)
        if (!reset) sr <= '0;
        else        sr <= {sr[4:0], bus.bf_en};
    assign bus.bf_valid = sr[5] & ~kill;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {bus.rd_en, bus.rd_addr_x, bus.rd_addr_y, bus.tw_addr, bus.bf_en, bus.wr_en,
                  bus.wr_addr_x, bus.wr_addr_y, busy, done, stage, err}, 0);
    endtask

    function automatic rd_t exp_rd(input int c);
        rd_t r;
        int  o, h;
        r.en = 1'b0; r.x = 0; r.y = 0; r.tw = 0; r.st = 0;
        if (c >= 1 && c <= 60 && (c - 1) % 15 < 8) begin
            o    = (c - 1) % 15;
            r.st = (c - 1) / 15;
            h    = 1 << (3 - r.st);
            r.en = 1'b1;
            r.x  = 2 * (o / h) * h + o % h;
            r.y  = r.x + h;
            r.tw = (o % h) << r.st;
        end
        return r;
    endfunction

    task automatic run(input int n, input int p1, input int p2, input int p3, input int kc);
        for (int c = 1; c <= n; c++) begin
            start = (c - 1 == 0 || c - 1 == p1 || c - 1 == p2 || c - 1 == p3);
            kill  = (c - 1 == kc);
            tick();
            tr[c].rd = bus.rd_en;     tr[c].x  = bus.rd_addr_x; tr[c].y  = bus.rd_addr_y;
            tr[c].tw = bus.tw_addr;   tr[c].st = stage;         tr[c].bfe = bus.bf_en;
            tr[c].wr = bus.wr_en;     tr[c].wx = bus.wr_addr_x; tr[c].wy = bus.wr_addr_y;
            tr[c].bsy = busy;         tr[c].dn = done;          tr[c].er = err;
        end
        start = 1'b0;
        kill  = 1'b0;
    endtask

    task automatic check_run(input string tag);
        rd_t e, w, b;
        int  nw, bad;
        nw = 0; bad = 0;
        for (int c = 1; c <= 62; c++) begin
            e = exp_rd(c);
            w = exp_rd(c - 7);
            b = exp_rd(c - 1);
            chk($sformatf("%s c%0d rd_en", tag, c), tr[c].rd, e.en);
            if (e.en) begin
                chk($sformatf("%s c%0d rd_x", tag, c), tr[c].x, e.x);
                chk($sformatf("%s c%0d rd_y", tag, c), tr[c].y, e.y);
                chk($sformatf("%s c%0d tw", tag, c), tr[c].tw, e.tw);
                chk($sformatf("%s c%0d stage", tag, c), tr[c].st, e.st);
            end
            chk($sformatf("%s c%0d bf_en", tag, c), tr[c].bfe, b.en);
            chk($sformatf("%s c%0d wr_en", tag, c), tr[c].wr, w.en);
            if (w.en) begin
                chk($sformatf("%s c%0d wr_x", tag, c), tr[c].wx, w.x);
                chk($sformatf("%s c%0d wr_y", tag, c), tr[c].wy, w.y);
            end
            chk($sformatf("%s c%0d busy", tag, c), tr[c].bsy, c <= 61);
            chk($sformatf("%s c%0d done", tag, c), tr[c].dn, c == 61);
            nw += int'(tr[c].wr);
            if (tr[c].rd && tr[c].wr && (c - 1) / 15 != (c - 8) / 15) bad++;
        end
        chk({tag, " wr_count"}, nw, 32);
        chk({tag, " overlap"}, bad, 0);
    endtask

    initial begin
        int nd, ne;
        // reset held with start high: everything stays zero
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("reset hold %0d", i), 0, 0 | {bus.rd_en, busy, done, err});
            chk_zero($sformatf("reset zero %0d", i));
        end
        reset = 1'b1;
        start = 1'b0;
        tick();
        chk_zero("idle after release");

        // default run with ignored starts at 5 and 61, new run at 63
        run(66, 5, 61, 63, -1);
        check_run("run1");
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("s0 x%0d", i), tr[1 + i].x, i);
            chk($sformatf("s0 y%0d", i), tr[1 + i].y, i + 8);
            chk($sformatf("s0 tw%0d", i), tr[1 + i].tw, i);
            chk($sformatf("s3 x%0d", i), tr[46 + i].x, 2 * i);
            chk($sformatf("s3 y%0d", i), tr[46 + i].y, 2 * i + 1);
            chk($sformatf("s3 tw%0d", i), tr[46 + i].tw, 0);
        end
        chk("barrier wr15", tr[15].wr, 1);
        chk("barrier rd15", tr[15].rd, 0);
        chk("barrier rd16", tr[16].rd, 1);
        chk("barrier x16", tr[16].x, 0);
        chk("barrier y16", tr[16].y, 4);
        chk("barrier tw16", tr[16].tw, 0);
        chk("barrier st16", tr[16].st, 1);
        nd = 0; ne = 0;
        for (int c = 1; c <= 66; c++) begin
            nd += int'(tr[c].dn);
            ne += int'(tr[c].er);
        end
        chk("single done", nd, 1);
        chk("run1 err clear", ne, 0);
        chk("idle busy c62", tr[62].bsy, 0);
        chk("idle busy c63", tr[63].bsy, 0);
        chk("restart busy c64", tr[64].bsy, 1);
        chk("restart rd c64", tr[64].rd, 1);
        chk("restart x c64", tr[64].x, 0);
        chk("restart y c64", tr[64].y, 8);

        // mid-run reset at cycle 20
        reset = 1'b0;
        tick();
        reset = 1'b1;
        run(20, -1, -1, -1, -1);
        chk("pre-reset busy", tr[20].bsy, 1);
        chk("pre-reset rd", tr[20].rd, 1);
        reset = 1'b0;
        #1;
        chk_zero("async reset");
        tick();
        chk_zero("reset hold a");
        tick();
        chk_zero("reset hold b");
        reset = 1'b1;
        tick();
        chk_zero("post-reset idle");
        run(62, -1, -1, -1, -1);
        check_run("rerun");

        // bf_valid suppressed at cycle 10
        run(62, -1, -1, -1, 10);
        check_run("kill");
        chk("err c10", tr[10].er, 0);
        chk("err c11", tr[11].er, 1);
        chk("err c62", tr[62].er, 1);
        run(1, -1, -1, -1, -1);
        chk("err cleared by start", tr[1].er, 0);
        chk("new run rd", tr[1].rd, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
